pkmc_sdram_refresh_sched: RTL and testbench
===========================================

PKMC_SDRAM_REFRESH_SCHED -- requirements
Module: pkmc_sdram_refresh_sched

Interface
REQ-001 The module SHALL have parameter INIT_WAIT, default 20000: power-up idle cycles before the first command.
REQ-002 The module SHALL have parameter REF_INTERVAL, default 780: cycles between refresh ticks.
REQ-003 The module SHALL have parameter INIT_REFS, default 8: auto-refreshes issued during init.
REQ-004 The module SHALL have parameter MAX_PEND, default 4: saturation limit of the pending-refresh counter (legal range 2..7).
REQ-005 The module SHALL have port clk_i  in  1  system clock; all logic runs on its rising edge.
REQ-006 The module SHALL have port rst_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-007 The module SHALL have port acc_req_i  in  1  host access request from the memory controller.
REQ-008 The module SHALL have port acc_gnt_o  out  1  access grant, held until acc_done_i.
REQ-009 The module SHALL have port acc_done_i  in  1  host access finished; sampled only while acc_gnt_o=1.
REQ-010 The module SHALL have port cmd_valid_o  out  1  command request to the SDRAM command FSM.
REQ-011 The module SHALL have port cmd_o  out  2  01=PRECHARGE, 10=AUTO_REFRESH, 11=LOAD_MODE, 00=NOP.
REQ-012 The module SHALL have port pch_all_o  out  1  1=precharge all banks (PCH_ALL), 0=one bank (PCH_ONE).
REQ-013 The module SHALL have port cmd_ack_i  in  1  command FSM accepted the command this cycle.
REQ-014 The module SHALL have port init_done_o  out  1  init sequence complete.
REQ-015 The module SHALL have port ref_pend_o  out  3  pending-refresh count.
REQ-016 The module SHALL have port ref_ovf_o  out  1  sticky: a tick was lost at saturation.

Function
REQ-017 The module SHALL sequence the states INIT_WAIT -> INIT_PCH -> INIT_REF -> INIT_LMR -> IDLE, and SHALL thereafter use the states IDLE, ACCESS, REF_PCH and REF_CMD.
REQ-018 In INIT_WAIT the module SHALL count INIT_WAIT cycles with cmd_valid_o=0, then enter INIT_PCH.
REQ-019 In INIT_PCH the module SHALL drive cmd_valid_o=1, cmd_o=01 and pch_all_o=1 until the cycle with cmd_ack_i=1, and SHALL then enter INIT_REF.
REQ-020 In INIT_REF the module SHALL issue cmd_o=10 until acknowledged, INIT_REFS times in total, with cmd_valid_o held high between back-to-back refreshes; after the last ack it SHALL enter INIT_LMR.
REQ-021 In INIT_LMR the module SHALL issue cmd_o=11 until acknowledged, and SHALL then set init_done_o=1 from the next cycle and enter IDLE.
REQ-022 The refresh timer SHALL run only when init_done_o=1; it SHALL load REF_INTERVAL-1 on init completion, decrement each cycle, and on zero generate a one-cycle tick and reload.
REQ-023 On a tick, ref_pend_o SHALL increment, saturating at MAX_PEND; a tick at saturation SHALL set ref_ovf_o, which clears only on reset.
REQ-024 On cmd_ack_i in REF_CMD, ref_pend_o SHALL decrement; a tick and a decrement in the same cycle SHALL leave ref_pend_o unchanged.
REQ-025 IDLE priority SHALL be: if ref_pend_o >= MAX_PEND-1, go to REF_PCH; else if acc_req_i=1, go to ACCESS; else if ref_pend_o > 0, go to REF_PCH; else stay in IDLE.
REQ-026 acc_gnt_o SHALL be registered: it rises the cycle after the IDLE decision, stays high throughout ACCESS, and falls the cycle after acc_done_i=1, with a return to IDLE.
REQ-027 An access SHALL never be pre-empted; pending refreshes SHALL accumulate during ACCESS.
REQ-028 REF_PCH SHALL issue PRECHARGE with pch_all_o=1 until acknowledged, then enter REF_CMD; REF_CMD SHALL issue AUTO_REFRESH until acknowledged, then return to IDLE.
REQ-029 In every state other than INIT_PCH and REF_PCH, pch_all_o SHALL be 0 (PCH_ONE).
REQ-030 When cmd_valid_o=0, cmd_o SHALL be 00.
REQ-031 cmd_o and pch_all_o SHALL remain stable while cmd_valid_o=1 and cmd_ack_i=0.
REQ-032 cmd_ack_i SHALL be ignored when cmd_valid_o=0.
REQ-033 acc_done_i SHALL be ignored outside ACCESS.

Reset
REQ-034 While rst_i=1 at a clock edge, the module SHALL enter INIT_WAIT with its counters cleared, from any state, including mid-command or mid-access.
REQ-035 Reset values SHALL be: acc_gnt_o=0, cmd_valid_o=0, cmd_o=00, pch_all_o=0, init_done_o=0, ref_pend_o=0, ref_ovf_o=0; the refresh timer is stopped.

Verification (INIT_WAIT=20, REF_INTERVAL=50, INIT_REFS=2, MAX_PEND=4, cmd_ack_i returned 1 cycle after cmd_valid_o unless stated)
REQ-036 Scenario init: release reset -> cmd_valid_o=0 for 20 cycles, then PRECHARGE/pch_all_o=1, AUTO_REFRESH x2, LOAD_MODE, then init_done_o=1.
REQ-037 Scenario idle refresh: no acc_req_i after init -> ref_pend_o=1 at 50 cycles, followed by PRECHARGE(all) + AUTO_REFRESH, after which ref_pend_o returns to 0.
REQ-038 Scenario contention: acc_req_i and ref_pend_o=1 simultaneously in IDLE -> access granted first; refresh follows after acc_done_i.
REQ-039 Scenario urgency/saturation: access held for 300 cycles -> ref_pend_o saturates at 4 and ref_ovf_o=1; after acc_done_i, a refresh precedes a still-asserted acc_req_i until ref_pend_o=2.
REQ-040 Scenario stall: cmd_ack_i held 0 for 10 cycles in REF_CMD -> cmd_o=10 is stable throughout; a tick during the stall raises ref_pend_o, and a tick in the ack cycle leaves it unchanged.
REQ-041 Scenario reset mid-access: rst_i=1 with acc_gnt_o=1 -> next cycle acc_gnt_o=0, init_done_o=0, and the init sequence restarts.

Source files
------------

// File: rtl/pkmc_sdram_refresh_sched.sv
// -----------------------------------------------------------------------------
// pkmc_sdram_refresh_sched
// Sequences the SDRAM power-up initialisation and then arbitrates between
// host accesses and periodic auto-refresh. Refresh ticks are counted while
// the memory is busy and are paid back before a new access once they become
// urgent.
//
// Ports
//   clk_i        in   system clock, rising edge
//   rst_i        in   synchronous active-high reset
//   acc_req_i    in   host access request
//   acc_gnt_o    out  access grant, held until acc_done_i
//   acc_done_i   in   host access finished (only looked at while granted)
//   cmd_valid_o  out  command request to the SDRAM command FSM
//   cmd_o        out  01=PRECHARGE 10=AUTO_REFRESH 11=LOAD_MODE 00=NOP
//   pch_all_o    out  1=precharge all banks, 0=single bank
//   cmd_ack_i    in   command accepted this cycle
//   init_done_o  out  initialisation sequence complete
//   ref_pend_o   out  pending-refresh count
//   ref_ovf_o    out  sticky: a refresh tick was lost at saturation
// -----------------------------------------------------------------------------
module pkmc_sdram_refresh_sched #(
    parameter int unsigned INIT_WAIT    = 20000,
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned INIT_REFS    = 8,
    parameter int unsigned MAX_PEND     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       acc_req_i,
    output logic       acc_gnt_o,
    input  logic       acc_done_i,
    output logic       cmd_valid_o,
    output logic [1:0] cmd_o,
    output logic       pch_all_o,
    input  logic       cmd_ack_i,
    output logic       init_done_o,
    output logic [2:0] ref_pend_o,
    output logic       ref_ovf_o
);

    // One counter serves both the power-up wait and the init refresh count.
    localparam int unsigned CNT_MAX = (INIT_WAIT > INIT_REFS) ? INIT_WAIT : INIT_REFS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W   = $clog2(REF_INTERVAL + 1);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_PCH = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;
    localparam logic [1:0] CMD_LMR = 2'b11;

    localparam logic [2:0]       PEND_MAX   = 3'(MAX_PEND);
    localparam logic [2:0]       PEND_URG   = 3'(MAX_PEND - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REF_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_INIT_PCH,
        S_INIT_REF,
        S_INIT_LMR,
        S_IDLE,
        S_ACCESS,
        S_REF_PCH,
        S_REF_CMD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [TMR_W-1:0] r_tmr;

    logic       r_acc_gnt;
    logic       r_cmd_valid;
    logic [1:0] r_cmd;
    logic       r_pch_all;
    logic       r_init_done;
    logic [2:0] r_pend;
    logic       r_ovf;

    logic       w_ack;
    logic       w_tick;
    logic       w_dec;
    logic       w_init_fin;
    logic       w_cmd_valid_nxt;
    logic [1:0] w_cmd_nxt;
    logic       w_pch_all_nxt;

    // An ack only counts while a command is actually being offered.
    assign w_ack      = cmd_ack_i & r_cmd_valid;
    assign w_tick     = r_init_done && (r_tmr == '0);
    assign w_dec      = (r_state == S_REF_CMD) && w_ack;
    assign w_init_fin = (r_state == S_INIT_LMR) && w_ack;

    // Next-state logic plus the command outputs decoded from the next state,
    // so every output is a flop that changes together with the state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_nxt       = CMD_NOP;
        w_pch_all_nxt   = 1'b0;

        case (r_state)
            S_INIT_WAIT: begin
                if (r_cnt == CNT_W'(INIT_WAIT - 1)) begin
                    w_state_nxt = S_INIT_PCH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_INIT_PCH: begin
                if (w_ack) begin
                    w_state_nxt = S_INIT_REF;
                    w_cnt_nxt   = '0;
                end
            end
            S_INIT_REF: begin
                if (w_ack) begin
                    if (r_cnt == CNT_W'(INIT_REFS - 1)) begin
                        w_state_nxt = S_INIT_LMR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_INIT_LMR: begin
                if (w_ack) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                // Urgent refresh beats access; access beats relaxed refresh.
                if (r_pend >= PEND_URG)   w_state_nxt = S_REF_PCH;
                else if (acc_req_i)       w_state_nxt = S_ACCESS;
                else if (r_pend != 3'd0)  w_state_nxt = S_REF_PCH;
            end
            S_ACCESS: begin
                if (acc_done_i) w_state_nxt = S_IDLE;
            end
            S_REF_PCH: begin
                if (w_ack) w_state_nxt = S_REF_CMD;
            end
            S_REF_CMD: begin
                if (w_ack) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase

        case (w_state_nxt)
            S_INIT_PCH, S_REF_PCH: begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_nxt       = CMD_PCH;
                w_pch_all_nxt   = 1'b1;
            end
            S_INIT_REF, S_REF_CMD: begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_nxt       = CMD_REF;
            end
            S_INIT_LMR: begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_nxt       = CMD_LMR;
            end
            default: ;
        endcase
    end

    // State, sequencing counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_INIT_WAIT;
            r_cnt       <= '0;
            r_acc_gnt   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= CMD_NOP;
            r_pch_all   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc_gnt   <= (w_state_nxt == S_ACCESS);
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd       <= w_cmd_nxt;
            r_pch_all   <= w_pch_all_nxt;
            if (w_init_fin) r_init_done <= 1'b1;
        end
    end

    // Refresh interval timer; idle until initialisation completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmr <= '0;
        end else if (w_init_fin) begin
            r_tmr <= TMR_RELOAD;
        end else if (r_init_done) begin
            r_tmr <= w_tick ? TMR_RELOAD : (r_tmr - TMR_W'(1));
        end
    end

    // Pending-refresh counter; a tick and a completed refresh cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= 3'd0;
            r_ovf  <= 1'b0;
        end else begin
            case ({w_tick, w_dec})
                2'b10: begin
                    if (r_pend == PEND_MAX) r_ovf  <= 1'b1;
                    else                    r_pend <= r_pend + 3'd1;
                end
                2'b01:   r_pend <= r_pend - 3'd1;
                default: ;
            endcase
        end
    end

    assign acc_gnt_o   = r_acc_gnt;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_o       = r_cmd;
    assign pch_all_o   = r_pch_all;
    assign init_done_o = r_init_done;
    assign ref_pend_o  = r_pend;
    assign ref_ovf_o   = r_ovf;

endmodule

// File: tb/tb_pkmc_sdram_refresh_sched.sv
// -----------------------------------------------------------------------------
// tb_pkmc_sdram_refresh_sched
// Scoreboard bench: each scenario queues the command/grant events it expects,
// a monitor pops and compares them as the DUT issues accepted commands and
// grant rising edges. A responder models the command FSM acknowledging one
// cycle after a request (longer for refreshes when ref_wait is raised).
// -----------------------------------------------------------------------------
module tb_pkmc_sdram_refresh_sched;

    localparam int unsigned P_INIT_WAIT = 20;
    localparam int unsigned P_REF_INT   = 50;
    localparam int unsigned P_INIT_REFS = 2;
    localparam int unsigned P_MAX_PEND  = 4;

    // Event encoding: {is_grant, pch_all, cmd[1:0]}
    localparam logic [3:0] EV_PCH = 4'b0101;
    localparam logic [3:0] EV_REF = 4'b0010;
    localparam logic [3:0] EV_LMR = 4'b0011;
    localparam logic [3:0] EV_GNT = 4'b1000;

    logic       clk_i;
    logic       rst_i;
    logic       acc_req_i;
    logic       acc_gnt_o;
    logic       acc_done_i;
    logic       cmd_valid_o;
    logic [1:0] cmd_o;
    logic       pch_all_o;
    logic       cmd_ack_i;
    logic       init_done_o;
    logic [2:0] ref_pend_o;
    logic       ref_ovf_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int lmr_ack_cyc = 0;
    int ref_wait = 1;
    logic [3:0] exp_q[$];

    pkmc_sdram_refresh_sched #(
        .INIT_WAIT   (P_INIT_WAIT),
        .REF_INTERVAL(P_REF_INT),
        .INIT_REFS   (P_INIT_REFS),
        .MAX_PEND    (P_MAX_PEND)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .acc_req_i  (acc_req_i),
        .acc_gnt_o  (acc_gnt_o),
        .acc_done_i (acc_done_i),
        .cmd_valid_o(cmd_valid_o),
        .cmd_o      (cmd_o),
        .pch_all_o  (pch_all_o),
        .cmd_ack_i  (cmd_ack_i),
        .init_done_o(init_done_o),
        .ref_pend_o (ref_pend_o),
        .ref_ovf_o  (ref_ovf_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int phase();
        return (cyc - t0) % int'(P_REF_INT);
    endfunction

    task automatic q_check(input string tag);
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Command FSM model: ack after ref_wait (refresh) or 1 idle cycle.
    initial begin
        int wcnt;
        int w;
        cmd_ack_i = 1'b0;
        wcnt = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (cmd_valid_o) begin
                w = (cmd_o == 2'b10 && init_done_o) ? ref_wait : 1;
                if (wcnt >= w) begin
                    cmd_ack_i = 1'b1;
                    wcnt = 0;
                end else begin
                    cmd_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                cmd_ack_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: protocol invariants and scoreboard pop.
    initial begin
        logic       prev_v;
        logic       prev_ack;
        logic       prev_gnt;
        logic [2:0] prev_cp;
        logic [3:0] ev;
        logic [3:0] e;
        logic       have;
        prev_v = 1'b0;
        prev_ack = 1'b0;
        prev_gnt = 1'b0;
        prev_cp = 3'd0;
        forever begin
            @(negedge clk_i);
            if (!cmd_valid_o)
                check("nop_when_invalid", 32'({pch_all_o, cmd_o}), 32'd0);
            else if (prev_v && !prev_ack)
                check("cmd_stable", 32'({pch_all_o, cmd_o}), 32'(prev_cp));
            have = 1'b0;
            ev = 4'd0;
            if (cmd_valid_o && cmd_ack_i) begin
                ev = {1'b0, pch_all_o, cmd_o};
                have = 1'b1;
            end else if (acc_gnt_o && !prev_gnt) begin
                ev = EV_GNT;
                have = 1'b1;
            end
            if (have) begin
                if (exp_q.size() == 0) begin
                    check("ev_unexpected", 32'(ev), 32'hFF);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_order", 32'(ev), 32'(e));
                end
                if (ev == EV_LMR) lmr_ack_cyc = cyc;
            end
            prev_v = cmd_valid_o;
            prev_ack = cmd_ack_i;
            prev_gnt = acc_gnt_o;
            prev_cp = {pch_all_o, cmd_o};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_init();
        rst_i = 1'b1;
        acc_req_i = 1'b0;
        acc_done_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_gnt",       32'(acc_gnt_o),   32'd0);
        check("rst_valid",     32'(cmd_valid_o), 32'd0);
        check("rst_cmd",       32'(cmd_o),       32'd0);
        check("rst_pch",       32'(pch_all_o),   32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        check("rst_pend",      32'(ref_pend_o),  32'd0);
        check("rst_ovf",       32'(ref_ovf_o),   32'd0);
        exp_q.push_back(EV_PCH);
        for (int i = 0; i < int'(P_INIT_REFS); i++) exp_q.push_back(EV_REF);
        exp_q.push_back(EV_LMR);
        rst_i = 1'b0;
        check("initwait_quiet", 32'(cmd_valid_o), 32'd0);
        for (int i = 1; i < int'(P_INIT_WAIT); i++) begin
            @(negedge clk_i);
            check("initwait_quiet", 32'(cmd_valid_o), 32'd0);
        end
        @(negedge clk_i);
        check("init_pch_valid", 32'(cmd_valid_o), 32'd1);
        check("init_pch_cmd",   32'({pch_all_o, cmd_o}), 32'b101);
        for (int i = 0; i < 40 && !init_done_o; i++) @(negedge clk_i);
        check("init_done",     32'(init_done_o), 32'd1);
        check("init_done_lat", 32'(cyc - lmr_ack_cyc), 32'd1);
        t0 = cyc;
        q_check("init_q_empty");
    endtask

    initial begin
        rst_i = 1'b1;
        acc_req_i = 1'b0;
        acc_done_i = 1'b0;

        // Power-up sequence
        do_init();

        // Idle refresh
        check("idle_ovf", 32'(ref_ovf_o), 32'd0);
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        for (int i = 0; i < 60 && ref_pend_o == 3'd0; i++) @(negedge clk_i);
        check("tick1_pend", 32'(ref_pend_o), 32'd1);
        check("tick1_lat",  32'(cyc - t0),   32'(P_REF_INT));
        for (int i = 0; i < 20 && ref_pend_o != 3'd0; i++) @(negedge clk_i);
        check("idle_ref_pend0", 32'(ref_pend_o), 32'd0);
        q_check("idle_ref_q");

        // Contention: request arrives with one refresh pending
        for (int i = 0; i < 80 && ref_pend_o == 3'd0; i++) @(negedge clk_i);
        check("cont_pend", 32'(ref_pend_o), 32'd1);
        acc_req_i = 1'b1;
        exp_q.push_back(EV_GNT);
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        @(negedge clk_i);
        check("cont_gnt",    32'(acc_gnt_o),   32'd1);
        check("cont_no_cmd", 32'(cmd_valid_o), 32'd0);
        acc_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        acc_done_i = 1'b1;
        @(negedge clk_i);
        acc_done_i = 1'b0;
        check("cont_gnt_fall", 32'(acc_gnt_o), 32'd0);
        for (int i = 0; i < 20 && ref_pend_o != 3'd0; i++) @(negedge clk_i);
        check("cont_pend0", 32'(ref_pend_o), 32'd0);
        q_check("cont_q");

        // Saturation and urgency
        acc_req_i = 1'b1;
        exp_q.push_back(EV_GNT);
        @(negedge clk_i);
        check("sat_gnt", 32'(acc_gnt_o), 32'd1);
        repeat (300) @(negedge clk_i);
        check("sat_pend",     32'(ref_pend_o), 32'(P_MAX_PEND));
        check("sat_ovf",      32'(ref_ovf_o),  32'd1);
        check("sat_gnt_held", 32'(acc_gnt_o),  32'd1);
        for (int i = 0; i < 60 && phase() != 5; i++) @(negedge clk_i);
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        exp_q.push_back(EV_GNT);
        acc_done_i = 1'b1;
        @(negedge clk_i);
        acc_done_i = 1'b0;
        check("sat_gnt_fall", 32'(acc_gnt_o), 32'd0);
        for (int i = 0; i < 40 && !acc_gnt_o; i++) @(negedge clk_i);
        check("sat_regnt",      32'(acc_gnt_o),  32'd1);
        check("sat_regnt_pend", 32'(ref_pend_o), 32'd2);
        acc_req_i = 1'b0;
        q_check("sat_q");
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        repeat (2) @(negedge clk_i);
        acc_done_i = 1'b1;
        @(negedge clk_i);
        acc_done_i = 1'b0;
        for (int i = 0; i < 30 && ref_pend_o != 3'd0; i++) @(negedge clk_i);
        check("sat_drain_pend0", 32'(ref_pend_o), 32'd0);
        check("ovf_sticky",      32'(ref_ovf_o),  32'd1);
        q_check("sat_drain_q");

        // Stall A: tick lands inside a stalled AUTO_REFRESH
        acc_req_i = 1'b1;
        exp_q.push_back(EV_GNT);
        @(negedge clk_i);
        check("stA_gnt", 32'(acc_gnt_o), 32'd1);
        acc_req_i = 1'b0;
        for (int i = 0; i < 120 && !(ref_pend_o == 3'd1 && phase() == 40); i++) @(negedge clk_i);
        check("stA_pend1", 32'(ref_pend_o), 32'd1);
        check("stA_phase", 32'(phase()),    32'd40);
        ref_wait = 10;
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        acc_done_i = 1'b1;
        @(negedge clk_i);
        acc_done_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check("stA_stalled",  32'({cmd_valid_o, cmd_o}), 32'b110);
        check("stA_pend_pre", 32'(ref_pend_o), 32'd1);
        @(negedge clk_i);
        check("stA_pend_tick", 32'(ref_pend_o), 32'd2);
        check("stA_still",     32'({cmd_valid_o, cmd_o}), 32'b110);
        repeat (5) @(negedge clk_i);
        check("stA_pend_ack", 32'(ref_pend_o),  32'd1);
        check("stA_released", 32'(cmd_valid_o), 32'd0);
        ref_wait = 1;
        for (int i = 0; i < 20 && ref_pend_o != 3'd0; i++) @(negedge clk_i);
        check("stA_pend0", 32'(ref_pend_o), 32'd0);
        q_check("stA_q");

        // Stall B: tick coincides with the refresh ack
        acc_req_i = 1'b1;
        exp_q.push_back(EV_GNT);
        @(negedge clk_i);
        check("stB_gnt", 32'(acc_gnt_o), 32'd1);
        acc_req_i = 1'b0;
        for (int i = 0; i < 120 && !(ref_pend_o == 3'd1 && phase() == 35); i++) @(negedge clk_i);
        check("stB_pend1", 32'(ref_pend_o), 32'd1);
        check("stB_phase", 32'(phase()),    32'd35);
        ref_wait = 10;
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        exp_q.push_back(EV_PCH);
        exp_q.push_back(EV_REF);
        acc_done_i = 1'b1;
        @(negedge clk_i);
        acc_done_i = 1'b0;
        repeat (13) @(negedge clk_i);
        check("stB_stalled",  32'({cmd_valid_o, cmd_o}), 32'b110);
        check("stB_pend_pre", 32'(ref_pend_o), 32'd1);
        @(negedge clk_i);
        check("stB_pend_same", 32'(ref_pend_o),  32'd1);
        check("stB_released",  32'(cmd_valid_o), 32'd0);
        ref_wait = 1;
        for (int i = 0; i < 20 && ref_pend_o != 3'd0; i++) @(negedge clk_i);
        check("stB_pend0", 32'(ref_pend_o), 32'd0);
        q_check("stB_q");

        // Reset in the middle of an access
        acc_req_i = 1'b1;
        exp_q.push_back(EV_GNT);
        @(negedge clk_i);
        check("rma_gnt", 32'(acc_gnt_o), 32'd1);
        rst_i = 1'b1;
        acc_req_i = 1'b0;
        @(negedge clk_i);
        check("rma_gnt_low",   32'(acc_gnt_o),   32'd0);
        check("rma_init_low",  32'(init_done_o), 32'd0);
        check("rma_ovf_clear", 32'(ref_ovf_o),   32'd0);
        q_check("rma_q");
        do_init();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
